// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed seven-segment scan driver with frame capture; optional SEG7_LZB_EN leading-zero blanking
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 1000,
  parameter int BLANK_CYC   = 2,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit COM_ACT_LOW = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [4*NUM_DIGITS-1:0] DIGITS,
  input  logic [NUM_DIGITS-1:0]   DP_IN,
  output logic [6:0]              SEG,
  output logic                    DP,
  output logic [NUM_DIGITS-1:0]   COM
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0]            SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = SEG_ACT_LOW;
  localparam logic [NUM_DIGITS-1:0] COM_OFF = COM_ACT_LOW ? '1 : '0;

  logic [PW-1:0]           p;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] frame_digits;
  logic [NUM_DIGITS-1:0]   frame_dp;
  logic                    load_pend;

  logic                  tick;
  logic                  last_digit;
  logic                  frame_load;
  logic                  slot_active;
  logic [3:0]            cur_digit;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [NUM_DIGITS-1:0] com_sel;
  logic [6:0]            seg_lit;

  // Slot timing: end of slot, end of frame, and whether the anti-ghost gap is over
  always_comb begin
    tick        = (p == PW'(SCAN_DIV - 1));
    last_digit  = (idx == IW'(NUM_DIGITS - 1));
    frame_load  = load_pend || (tick && last_digit);
    slot_active = (int'(p) >= BLANK_CYC);
  end

  // Pick the frame nibble, DP request and one-hot select for the current slot
  always_comb begin
    cur_digit = 4'd0;
    cur_dp    = 1'b0;
    com_sel   = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_digit  = frame_digits[4*k +: 4];
        cur_dp     = frame_dp[k];
        com_sel[k] = 1'b1;
      end
    end
  end

`ifdef SEG7_LZB_EN
  logic [NUM_DIGITS-1:0] blank_vec;

  // A digit is blank when it and every digit above it are zero; digit 0 always shows
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    blank_vec  = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      upper_zero   = upper_zero && (frame_digits[4*k +: 4] == 4'd0);
      blank_vec[k] = upper_zero;
    end
  end

  // Blank flag of the digit currently being scanned
  always_comb begin
    cur_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) cur_blank = blank_vec[k];
    end
  end
`else
  assign cur_blank = 1'b0;
`endif

  // BCD to segments {g,f,e,d,c,b,a}, active-high here; non-BCD codes show a dash
  always_comb begin
    case (cur_digit)
      4'd0:    seg_lit = 7'h3F;
      4'd1:    seg_lit = 7'h06;
      4'd2:    seg_lit = 7'h5B;
      4'd3:    seg_lit = 7'h4F;
      4'd4:    seg_lit = 7'h66;
      4'd5:    seg_lit = 7'h6D;
      4'd6:    seg_lit = 7'h7D;
      4'd7:    seg_lit = 7'h07;
      4'd8:    seg_lit = 7'h7F;
      4'd9:    seg_lit = 7'h6F;
      default: seg_lit = 7'h40;
    endcase
    if (cur_blank) seg_lit = 7'h00;
  end

  // Scan counters, tear-free frame capture and registered pin drive
  always_ff @(posedge CLK) begin
    if (RST) begin
      p            <= '0;
      idx          <= '0;
      frame_digits <= '0;
      frame_dp     <= '0;
      load_pend    <= 1'b1;
      SEG          <= SEG_OFF;
      DP           <= DP_OFF;
      COM          <= COM_OFF;
    end else begin
      p <= tick ? '0 : p + 1'b1;
      if (tick) idx <= last_digit ? '0 : idx + 1'b1;
      if (frame_load) begin
        frame_digits <= DIGITS;
        frame_dp     <= DP_IN;
        load_pend    <= 1'b0;
      end
      SEG <= SEG_ACT_LOW ? ~seg_lit : seg_lit;
      DP  <= SEG_ACT_LOW ? ~cur_dp : cur_dp;
      if (slot_active) COM <= COM_ACT_LOW ? ~com_sel : com_sel;
      else             COM <= COM_OFF;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver against a cycle-count reference model
module tb_seg7_scan_driver;

    localparam int N = 4;
    localparam int S = 8;
    localparam int B = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   digits;
    logic [3:0]    dp_in;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    com;

    int            check_cnt = 0;
    int            fail_cnt  = 0;
    int unsigned   k = 0;
    logic [15:0]   m_dig = '0;
    logic [3:0]    m_dp  = '0;
    logic [11:0]   exp_q[$];
    int            wait_cnt;

    seg7_scan_driver #(
        .NUM_DIGITS(N), .SCAN_DIV(S), .BLANK_CYC(B), .SEG_ACT_LOW(1'b1), .COM_ACT_LOW(1'b1)
    ) dut (
        .CLK(clk), .RST(rst), .DIGITS(digits), .DP_IN(dp_in), .SEG(seg), .DP(dp), .COM(com)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] lit_pattern(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    function automatic logic [11:0] expect_out(input int unsigned kk, input logic [15:0] fd, input logic [3:0] fdp);
        int prev, pp, ii, d;
        logic [6:0] lit;
        logic [3:0] c;
        prev = int'(kk) - 1;
        pp   = prev % S;
        ii   = (prev / S) % N;
        d    = int'((fd >> (4 * ii)) & 16'h000F);
        lit  = lit_pattern(d);
`ifdef SEG7_LZB_EN
        if (ii > 0 && (fd >> (4 * ii)) == 16'h0000) lit = 7'h00;
`endif
        c = (pp < B) ? 4'hF : ~(4'b0001 << ii);
        return {~lit, ~fdp[ii], c};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            k     = 0;
            m_dig = '0;
            m_dp  = '0;
            exp_q.push_back({7'h7F, 1'b1, 4'hF});
        end else begin
            k = k + 1;
            exp_q.push_back(expect_out(k, m_dig, m_dp));
            if (k == 1 || (k % (N * S)) == 0) begin
                m_dig = digits;
                m_dp  = dp_in;
            end
        end
    end

    always @(negedge clk) begin
        logic [11:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_cnt = check_cnt + 1;
            if ({seg, dp, com} !== e) begin
                fail_cnt = fail_cnt + 1;
                $display("FAIL scan_out t=%0t: got SEG=%h DP=%b COM=%h, expected SEG=%h DP=%b COM=%h",
                         $time, seg, dp, com, e[11:5], e[4], e[3:0]);
            end
        end
    end

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        check_cnt = check_cnt + 1;
        if (got !== exp) begin
            fail_cnt = fail_cnt + 1;
            $display("FAIL %s t=%0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic rand_digits();
        logic [15:0] v;
        v = 16'($urandom);
        for (int i = 0; i < 4; i++) if ($urandom_range(0, 2) == 0) v[4*i +: 4] = 4'h0;
        digits = v;
        dp_in  = 4'($urandom);
    endtask

    initial begin
        rst    = 1'b1;
        digits = 16'h4321;
        dp_in  = 4'b0000;
        step(3);
        check_val("reset_state", {20'd0, seg, dp, com}, {20'd0, 7'h7F, 1'b1, 4'hF});
        rst = 1'b0;
        wait_cnt = 0;
        while (com !== 4'hE && wait_cnt < 10) begin
            step(1);
            wait_cnt = wait_cnt + 1;
        end
        check_val("first_com_wait_expired", {31'd0, (com === 4'hE)}, 32'd1);
        check_val("first_com_latency", 32'(wait_cnt), 32'd2);
        step(10);
        digits = 16'h8765;
        step(60);
        digits = 16'h432C;
        dp_in  = 4'b0010;
        step(40);
        digits = 16'h0050;
        dp_in  = 4'b0000;
        step(40);
        digits = 16'h0000;
        step(40);
        step(21);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        digits = 16'h9F0A;
        step(45);
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 9))
                0: begin
                    rst = 1'b1;
                    step(int'($urandom_range(1, 2)));
                    rst = 1'b0;
                end
                1, 2, 3, 4: rand_digits();
                default: step(int'($urandom_range(1, 40)));
            endcase
        end
        step(3);
        $display("End of test - %0d assertions evaluated, %0d failures", check_cnt, fail_cnt);
        $finish;
    end

endmodule
